// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write master: FSM and phase encodings, OV7725 ID,
// and the quarter-period divider calculation.
package sccb_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_ID    = 4'd2;
  localparam logic [3:0] ST_ACK1  = 4'd3;
  localparam logic [3:0] ST_ADDR  = 4'd4;
  localparam logic [3:0] ST_ACK2  = 4'd5;
  localparam logic [3:0] ST_DATA  = 4'd6;
  localparam logic [3:0] ST_ACK3  = 4'd7;
  localparam logic [3:0] ST_STOP  = 4'd8;

  localparam logic [1:0] PH_Q0 = 2'd0;
  localparam logic [1:0] PH_Q1 = 2'd1;
  localparam logic [1:0] PH_Q2 = 2'd2;
  localparam logic [1:0] PH_Q3 = 2'd3;

  localparam logic [7:0] DEV_ID_OV7725 = 8'h42;

  function automatic int unsigned calc_cnt_quarter(input int unsigned sys_clk_freq,
                                                   input int unsigned scl_freq);
    return sys_clk_freq / (4 * scl_freq);
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-SCL-period counter: pulses o_tick every CNT_QUARTER cycles and steps the
// 2-bit phase q0..q3; counter and phase are held at zero while disabled.
module sccb_tick_gen
  import sccb_pkg::*;
#(
  parameter int unsigned CNT_QUARTER = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_phase
);

  localparam int unsigned   CW       = (CNT_QUARTER > 1) ? $clog2(CNT_QUARTER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_QUARTER - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  logic          w_tick;

  assign w_tick  = i_en && (r_cnt == CNT_LAST);
  assign o_tick  = w_tick;
  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= PH_Q0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= PH_Q0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_phase <= r_phase + 2'd1;
    end
  end

endmodule

// File: rtl/sccb_wr_master.sv
// SCCB 3-phase write master: START, DEV_ID, REG_ADDR, REG_VAL, STOP per cfg_start.
// Optional macro SCCB_ACK_CHECK_EN enables NACK detection with a sticky ack_err.
module sccb_wr_master
  import sccb_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ     = 250_000,
  parameter logic [7:0]  DEV_ID       = DEV_ID_OV7725
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [15:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        sccb_scl,
  output logic        sccb_sda_o,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_i,
  output logic        ack_err
);

  localparam int unsigned CNT_QUARTER = calc_cnt_quarter(SYS_CLK_FREQ, SCL_FREQ);

  logic [3:0] r_state, w_state_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_addr, r_val;
  logic       r_busy, r_cfg_end, r_ack_err;
  logic       r_scl, r_sda_o, r_sda_oe;
  logic       w_en, w_tick, w_bit_end, w_accept, w_in_ack, w_nack;
  logic [1:0] w_phase, w_phase_nxt;
  logic       w_scl_nxt, w_sda_nxt, w_oe_nxt;

  assign w_en        = (r_state != ST_IDLE);
  assign w_bit_end   = w_tick && (w_phase == PH_Q3);
  assign w_phase_nxt = w_phase + {1'b0, w_tick};
  assign w_in_ack    = (r_state == ST_ACK1) || (r_state == ST_ACK2) || (r_state == ST_ACK3);
  // busy is still high during the cfg_end cycle, so a start there is dropped
  assign w_accept    = cfg_start && (r_state == ST_IDLE) && !r_busy;

  sccb_tick_gen #(.CNT_QUARTER(CNT_QUARTER)) u_tick_gen (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_en    (w_en),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

`ifdef SCCB_ACK_CHECK_EN
  logic r_nack;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                     r_nack <= 1'b0;
    else if (w_in_ack && w_tick && w_phase == PH_Q2)    r_nack <= sccb_sda_i;
  end
  assign w_nack = r_nack;
`else
  logic w_unused_sda;
  assign w_unused_sda = sccb_sda_i;
  assign w_nack       = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_START;
      ST_START: if (w_bit_end) begin
        w_state_nxt  = ST_ID;
        w_shift_nxt  = DEV_ID;
        w_bitcnt_nxt = 3'd7;
      end
      ST_ID, ST_ADDR, ST_DATA: if (w_bit_end) begin
        if (r_bitcnt == 3'd0) begin
          w_state_nxt = (r_state == ST_ID)   ? ST_ACK1 :
                        (r_state == ST_ADDR) ? ST_ACK2 : ST_ACK3;
        end else begin
          w_shift_nxt  = {r_shift[6:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - 3'd1;
        end
      end
      ST_ACK1: if (w_bit_end) begin
        if (w_nack) w_state_nxt = ST_STOP;
        else begin
          w_state_nxt  = ST_ADDR;
          w_shift_nxt  = r_addr;
          w_bitcnt_nxt = 3'd7;
        end
      end
      ST_ACK2: if (w_bit_end) begin
        if (w_nack) w_state_nxt = ST_STOP;
        else begin
          w_state_nxt  = ST_DATA;
          w_shift_nxt  = r_val;
          w_bitcnt_nxt = 3'd7;
        end
      end
      ST_ACK3: if (w_bit_end) w_state_nxt = ST_STOP;
      ST_STOP: if (w_bit_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pins are decoded from next state/phase so the registered outputs line up with phase entry
  always_comb begin
    w_scl_nxt = 1'b1;
    w_sda_nxt = 1'b1;
    w_oe_nxt  = 1'b0;
    case (w_state_nxt)
      ST_START: begin
        w_oe_nxt  = 1'b1;
        w_sda_nxt = (w_phase_nxt < PH_Q2);
      end
      ST_ID, ST_ADDR, ST_DATA: begin
        w_scl_nxt = (w_phase_nxt >= PH_Q2);
        w_oe_nxt  = 1'b1;
        w_sda_nxt = w_shift_nxt[7];
      end
      ST_ACK1, ST_ACK2, ST_ACK3: w_scl_nxt = (w_phase_nxt >= PH_Q2);
      ST_STOP: begin
        w_scl_nxt = (w_phase_nxt != PH_Q0);
        w_oe_nxt  = 1'b1;
        w_sda_nxt = (w_phase_nxt >= PH_Q2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_val     <= '0;
      r_busy    <= 1'b0;
      r_cfg_end <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_o   <= 1'b1;
      r_sda_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      if (w_accept) begin
        r_addr <= cfg_data[15:8];
        r_val  <= cfg_data[7:0];
      end
      if (w_accept)       r_busy <= 1'b1;
      else if (r_cfg_end) r_busy <= 1'b0;
      r_cfg_end <= (r_state == ST_STOP) && w_bit_end;
      if (w_bit_end && w_in_ack && w_nack) r_ack_err <= 1'b1;
      r_scl     <= w_scl_nxt;
      r_sda_o   <= w_sda_nxt;
      r_sda_oe  <= w_oe_nxt;
    end
  end

  assign cfg_end     = r_cfg_end;
  assign busy        = r_busy;
  assign sccb_scl    = r_scl;
  assign sccb_sda_o  = r_sda_o;
  assign sccb_sda_oe = r_sda_oe;
  assign ack_err     = r_ack_err;

endmodule

// File: tb/tb_sccb_wr_master.sv
// Bench for sccb_wr_master: bus monitor decodes SCL/SDA frames into a queue that is
// checked against expected frames pushed when each write is requested.
`timescale 1ns/1ps
module tb_sccb_wr_master;

  localparam int unsigned SYS_F    = 50_000_000;
  localparam int unsigned SCL_F    = 2_500_000;
  localparam int          Q        = SYS_F / (4 * SCL_F);
  localparam int          FULL_LAT = 1 + 29 * 4 * Q;
  localparam int          NACK_LAT = 1 + 20 * 4 * Q;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_end, busy, scl, sda_o, sda_oe, sda_i, ack_err;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [23:0] data; int nbytes; } frame_t;
  frame_t exp_q[$];
  frame_t got_q[$];

  logic        prev_scl = 1'b1, prev_sda = 1'b1, slave_low = 1'b0, nack_addr = 1'b0;
  int          mon_bits = 0, mon_bytes = 0, n_start = 0, n_stop = 0, n_end = 0;
  logic [7:0]  mon_sh = '0;
  logic [23:0] mon_data = '0;

  // released SDA floats high unless the slave model pulls it low for ACK
  assign sda_i = sda_oe ? sda_o : !slave_low;

  always #10 clk = ~clk;

  sccb_wr_master #(.SYS_CLK_FREQ(SYS_F), .SCL_FREQ(SCL_F), .DEV_ID(8'h42)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .cfg_start   (cfg_start),
    .cfg_data    (cfg_data),
    .cfg_end     (cfg_end),
    .busy        (busy),
    .sccb_scl    (scl),
    .sccb_sda_o  (sda_o),
    .sccb_sda_oe (sda_oe),
    .sccb_sda_i  (sda_i),
    .ack_err     (ack_err)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits  <= 0;
      mon_bytes <= 0;
      mon_data  <= '0;
      slave_low <= 1'b0;
    end else begin
      if (cfg_end) n_end <= n_end + 1;
      if (prev_scl && scl && prev_sda && !sda_i) begin
        n_start   <= n_start + 1;
        mon_bits  <= 0;
        mon_bytes <= 0;
        mon_data  <= '0;
      end else if (prev_scl && scl && !prev_sda && sda_i) begin
        n_stop <= n_stop + 1;
        got_q.push_back('{data: mon_data, nbytes: mon_bytes});
      end else if (!prev_scl && scl) begin
        if (mon_bits == 8) begin
          mon_bits  <= 0;
          mon_bytes <= mon_bytes + 1;
          mon_data  <= {mon_data[15:0], mon_sh};
        end else begin
          mon_bits <= mon_bits + 1;
          mon_sh   <= {mon_sh[6:0], sda_i};
        end
      end else if (prev_scl && !scl) begin
        slave_low <= (mon_bits == 8) && !(nack_addr && mon_bytes == 1);
      end
    end
    prev_scl <= scl;
    prev_sda <= sda_i;
  end

  task automatic run_frame(input logic [15:0] d, input int glitch_at,
                           input logic [15:0] glitch_d, output int lat);
    int n = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_data  = d;
    lat = -1;
    while (n < 2 * FULL_LAT) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin cfg_start = 1'b0; cfg_data = ~d; end
      if (n == glitch_at) begin cfg_start = 1'b1; cfg_data = glitch_d; end
      else if (n == glitch_at + 1) begin cfg_start = 1'b0; cfg_data = ~d; end
      if (cfg_end) begin lat = n; break; end
    end
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cfg_end !== 1'b0) begin errors++; $display("FAIL rst_cfg_end got %b req 0", cfg_end); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b req 0", busy); end
    checks++; if (scl !== 1'b1)     begin errors++; $display("FAIL rst_scl got %b req 1", scl); end
    checks++; if (sda_o !== 1'b1)   begin errors++; $display("FAIL rst_sda_o got %b req 1", sda_o); end
    checks++; if (sda_oe !== 1'b0)  begin errors++; $display("FAIL rst_sda_oe got %b req 0", sda_oe); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b req 0", ack_err); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({scl, sda_oe, busy} !== 3'b100) begin errors++; $display("FAIL idle_after_rst got %b req 100", {scl, sda_oe, busy}); end
  endtask

  task automatic test_single_frame();
    int lat; frame_t g, e;
    exp_q.push_back('{data: 24'h421206, nbytes: 3});
    run_frame(16'h1206, 0, 16'h0, lat);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL t1_latency got %0d req %0d", lat, FULL_LAT); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_at_end got %b req 1", busy); end
    @(posedge clk); #1;
    checks++; if ({cfg_end, busy} !== 2'b00) begin errors++; $display("FAIL t1_after_end got %b req 00", {cfg_end, busy}); end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL t1_frame got none req %h", e.data); end
    else begin
      g = got_q.pop_front();
      if (g.data !== e.data || g.nbytes != e.nbytes) begin
        errors++; $display("FAIL t1_frame got %h/%0d req %h/%0d", g.data, g.nbytes, e.data, e.nbytes);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; frame_t g, e; int s0;
    logic [15:0] d[2];
    d[0] = 16'h5a5a; d[1] = 16'h3d03;
    s0 = n_start;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{data: {8'h42, d[i]}, nbytes: 3});
      run_frame(d[i], 0, 16'h0, lat);
      checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL b2b_latency[%0d] got %0d req %0d", i, lat, FULL_LAT); end
      if (i == 0) begin
        cfg_start = 1'b1;
        cfg_data  = 16'hbeef;
      end
    end
    @(posedge clk); #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL b2b_idle_scl got %b req 1", scl); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL b2b_frame[%0d] got none req %h", i, e.data); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.nbytes != e.nbytes) begin
          errors++; $display("FAIL b2b_frame[%0d] got %h/%0d req %h/%0d", i, g.data, g.nbytes, e.data, e.nbytes);
        end
      end
    end
    checks++; if (n_start - s0 != 2 || n_stop != n_start) begin
      errors++; $display("FAIL b2b_bus_events got start %0d stop %0d req start 2 stop=start", n_start - s0, n_stop);
    end
  endtask

  task automatic test_midframe_ignore();
    int lat; frame_t g, e; int e0;
    e0 = n_end;
    exp_q.push_back('{data: 24'h420a1b, nbytes: 3});
    run_frame(16'h0a1b, FULL_LAT / 2, 16'hffff, lat);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL mid_latency got %0d req %0d", lat, FULL_LAT); end
    repeat (4 * Q * 3) @(posedge clk);
    #1;
    checks++; if (n_end - e0 != 1) begin errors++; $display("FAIL mid_cfg_end_count got %0d req 1", n_end - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b req 0", busy); end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL mid_frame got %0d frames req 1", got_q.size()); got_q.delete(); end
    else begin
      g = got_q.pop_front();
      if (g.data !== e.data || g.nbytes != e.nbytes) begin
        errors++; $display("FAIL mid_frame got %h/%0d req %h/%0d", g.data, g.nbytes, e.data, e.nbytes);
      end
    end
  endtask

  task automatic test_nack();
    int lat, exp_lat; frame_t g, e; logic exp_err;
`ifdef SCCB_ACK_CHECK_EN
    exp_q.push_back('{data: 24'h004255, nbytes: 2});
    exp_lat = NACK_LAT; exp_err = 1'b1;
`else
    exp_q.push_back('{data: 24'h4255aa, nbytes: 3});
    exp_lat = FULL_LAT; exp_err = 1'b0;
`endif
    exp_q.push_back('{data: 24'h426b01, nbytes: 3});
    nack_addr = 1'b1;
    run_frame(16'h55aa, 0, 16'h0, lat);
    nack_addr = 1'b0;
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL nack_latency got %0d req %0d", lat, exp_lat); end
    checks++; if (ack_err !== exp_err) begin errors++; $display("FAIL nack_ack_err got %b req %b", ack_err, exp_err); end
    run_frame(16'h6b01, 0, 16'h0, lat);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL nack_next_latency got %0d req %0d", lat, FULL_LAT); end
    checks++; if (ack_err !== exp_err) begin errors++; $display("FAIL nack_sticky got %b req %b", ack_err, exp_err); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL nack_frame[%0d] got none req %h", i, e.data); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.nbytes != e.nbytes) begin
          errors++; $display("FAIL nack_frame[%0d] got %h/%0d req %h/%0d", i, g.data, g.nbytes, e.data, e.nbytes);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; frame_t g, e;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_data  = 16'h7788;
    for (int n = 1; n <= 1 + 23 * 4 * Q + 2 * Q; n++) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    checks++; if ({busy, scl, sda_oe} !== 3'b111) begin errors++; $display("FAIL rmid_in_frame got %b req 111", {busy, scl, sda_oe}); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({scl, sda_oe, busy} !== 3'b100) begin errors++; $display("FAIL rmid_outputs got %b req 100", {scl, sda_oe, busy}); end
    checks++; if ({cfg_end, ack_err, sda_o} !== 3'b001) begin errors++; $display("FAIL rmid_flags got %b req 001", {cfg_end, ack_err, sda_o}); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_no_frame got %0d req 0", got_q.size()); got_q.delete(); end
    exp_q.push_back('{data: 24'h427788, nbytes: 3});
    run_frame(16'h7788, 0, 16'h0, lat);
    checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL rmid_latency got %0d req %0d", lat, FULL_LAT); end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL rmid_frame got none req %h", e.data); end
    else begin
      g = got_q.pop_front();
      if (g.data !== e.data || g.nbytes != e.nbytes) begin
        errors++; $display("FAIL rmid_frame got %h/%0d req %h/%0d", g.data, g.nbytes, e.data, e.nbytes);
      end
    end
  endtask

  task automatic test_sequencer();
    int lat; frame_t g, e; int s0;
    logic [15:0] d;
    s0 = n_start;
    for (int i = 0; i < 69; i++) begin
      d = {8'(8'h10 + i), 8'(i * 7 + 3)};
      exp_q.push_back('{data: {8'h42, d}, nbytes: 3});
      run_frame(d, 0, 16'h0, lat);
      checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL seq_latency[%0d] got %0d req %0d", i, lat, FULL_LAT); end
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL seq_frame[%0d] got none req %h", i, e.data); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.nbytes != e.nbytes) begin
          errors++; $display("FAIL seq_frame[%0d] got %h/%0d req %h/%0d", i, g.data, g.nbytes, e.data, e.nbytes);
        end
      end
    end
    repeat (8 * Q * 4) @(posedge clk);
    #1;
    checks++; if (n_start - s0 != 69) begin errors++; $display("FAIL seq_start_count got %0d req 69", n_start - s0); end
    checks++; if ({busy, scl, sda_oe} !== 3'b010) begin errors++; $display("FAIL seq_idle got %b req 010", {busy, scl, sda_oe}); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL seq_extra_frames got %0d req 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_midframe_ignore();
    test_nack();
    test_reset_mid();
    test_sequencer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
